// File: rtl/fft_bit_reorder_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_bit_reorder_if
// Purpose  : Stream bundle for fft_bit_reorder: sample input and reordered
//            output, plus the optional o_idx (FFT_BIT_REORDER_IDX_EN).
// Revision : 1.0 - initial release
// ============================================================================
interface fft_bit_reorder_if #(
    parameter int DATA_W = 40,
    parameter int DEPTH  = 256
);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              i_vld;
    logic [DATA_W-1:0] i_data;
    logic              o_vld;
    logic              o_new_fft;
    logic [DATA_W-1:0] o_data;
`ifdef FFT_BIT_REORDER_IDX_EN
    logic [c_AW-1:0]   o_idx;

    modport master (output i_vld, output i_data,
                    input  o_vld, input  o_new_fft, input o_data, input o_idx);
    modport slave  (input  i_vld, input  i_data,
                    output o_vld, output o_new_fft, output o_data, output o_idx);
`else
    modport master (output i_vld, output i_data,
                    input  o_vld, input  o_new_fft, input o_data);
    modport slave  (input  i_vld, input  i_data,
                    output o_vld, output o_new_fft, output o_data);
`endif
endinterface
`default_nettype wire

// File: rtl/fft_bit_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_bit_reorder
// Purpose  : Ping-pong reorder of bit-reversed FFT frames into natural order.
//            Define FFT_BIT_REORDER_IDX_EN to add the o_idx bin index output.
// Revision : 1.0 - initial release
// ============================================================================
module fft_bit_reorder #(
    parameter int DATA_W = 40,
    parameter int DEPTH  = 256
) (
    input  logic                mclk,
    input  logic                i_init_n,
    fft_bit_reorder_if.slave    bus
);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [0:2*DEPTH-1];
    logic [c_AW-1:0]   r_wr_cnt;
    logic [c_AW-1:0]   w_wr_rev;
    logic              r_bank;
    logic              r_primed;
    logic              r_vld;
    logic              r_new_fft;
    logic [DATA_W-1:0] r_data;

    generate
        for (genvar gi = 0; gi < c_AW; gi++) begin : g_bitrev
            assign w_wr_rev[gi] = r_wr_cnt[c_AW-1-gi];
        end
    endgenerate

    // RAM is deliberately not cleared by reset; reads of the other bank are
    // only exposed once a full frame has landed there.
    always_ff @(posedge mclk) begin
        if (i_init_n && bus.i_vld) begin
            r_mem[{r_bank, w_wr_rev}] <= bus.i_data;
        end
    end

    always_ff @(posedge mclk) begin
        if (!i_init_n) begin
            r_wr_cnt  <= '0;
            r_bank    <= 1'b0;
            r_primed  <= 1'b0;
            r_vld     <= 1'b0;
            r_new_fft <= 1'b0;
            r_data    <= '0;
        end else begin
            r_vld     <= bus.i_vld & r_primed;
            r_new_fft <= bus.i_vld & r_primed & (r_wr_cnt == '0);
            if (bus.i_vld) begin
                r_data   <= r_mem[{~r_bank, r_wr_cnt}];
                r_wr_cnt <= r_wr_cnt + c_AW'(1);
                if (&r_wr_cnt) begin
                    r_bank   <= ~r_bank;
                    r_primed <= 1'b1;
                end
            end
        end
    end

    assign bus.o_vld     = r_vld;
    assign bus.o_new_fft = r_new_fft;
    assign bus.o_data    = r_data;

`ifdef FFT_BIT_REORDER_IDX_EN
    logic [c_AW-1:0] r_idx;

    // Index only moves on cycles that produce a valid output word.
    always_ff @(posedge mclk) begin
        if (!i_init_n) begin
            r_idx <= '0;
        end else if (bus.i_vld && r_primed) begin
            r_idx <= r_wr_cnt;
        end
    end

    assign bus.o_idx = r_idx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_bit_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bit_reorder
// Purpose  : Directed self-checking bench for fft_bit_reorder (DEPTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bit_reorder;
    localparam int c_DW = 8;
    localparam int c_DP = 8;

    logic mclk   = 1'b0;
    logic init_n = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    always #5 mclk = ~mclk;

    fft_bit_reorder_if #(.DATA_W(c_DW), .DEPTH(c_DP)) bus ();

    fft_bit_reorder #(.DATA_W(c_DW), .DEPTH(c_DP)) dut (
        .mclk     (mclk),
        .i_init_n (init_n),
        .bus      (bus.slave)
    );

    function automatic logic [7:0] br3(input int k);
        logic [2:0] b;
        b = k[2:0];
        return {5'd0, b[0], b[1], b[2]};
    endfunction

    // Apply one cycle of inputs; outputs are sampled 1 ns after the edge.
    task automatic step(input logic rn, input logic v, input logic [7:0] d);
        init_n     = rn;
        bus.i_vld  = v;
        bus.i_data = d;
        @(posedge mclk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 8'hAA);
        n_cmp++; if (bus.o_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", bus.o_vld); end
        n_cmp++; if (bus.o_new_fft !== 1'b0) begin n_err++; $display("FAIL reset_new: got %b want 0", bus.o_new_fft); end
        n_cmp++; if (bus.o_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.o_data); end
`ifdef FFT_BIT_REORDER_IDX_EN
        n_cmp++; if (bus.o_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", bus.o_idx); end
`endif
    endtask

    task automatic test_priming();
        step(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < c_DP; k++) begin
            step(1'b1, 1'b1, 8'h10 + br3(k));
            n_cmp++; if (bus.o_vld !== 1'b0) begin n_err++; $display("FAIL prime_vld k=%0d: got %b want 0", k, bus.o_vld); end
            n_cmp++; if (bus.o_new_fft !== 1'b0) begin n_err++; $display("FAIL prime_new k=%0d: got %b want 0", k, bus.o_new_fft); end
        end
    endtask

    task automatic test_natural_order();
        logic [7:0] exp;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < c_DP; k++) begin
                step(1'b1, 1'b1, 8'h20 + 8'(f * 16) + br3(k));
                exp = 8'h10 + 8'(f * 16) + 8'(k);
                n_cmp++; if (bus.o_vld !== 1'b1) begin n_err++; $display("FAIL nat_vld f=%0d k=%0d: got %b want 1", f, k, bus.o_vld); end
                n_cmp++; if (bus.o_new_fft !== (k == 0)) begin n_err++; $display("FAIL nat_new f=%0d k=%0d: got %b want %b", f, k, bus.o_new_fft, (k == 0)); end
                n_cmp++; if (bus.o_data !== exp) begin n_err++; $display("FAIL nat_data f=%0d k=%0d: got %h want %h", f, k, bus.o_data, exp); end
            end
        end
    endtask

    task automatic test_reset_vs_vld();
        logic [7:0] exp;
        step(1'b0, 1'b1, 8'h99);
        n_cmp++; if (bus.o_vld !== 1'b0) begin n_err++; $display("FAIL rstv_vld: got %b want 0", bus.o_vld); end
        n_cmp++; if (bus.o_data !== 8'h00) begin n_err++; $display("FAIL rstv_data: got %h want 00", bus.o_data); end
        for (int k = 0; k < c_DP; k++) begin
            step(1'b1, 1'b1, 8'h60 + br3(k));
            n_cmp++; if (bus.o_vld !== 1'b0) begin n_err++; $display("FAIL rstv_prime k=%0d: got %b want 0", k, bus.o_vld); end
        end
        for (int k = 0; k < c_DP; k++) begin
            step(1'b1, 1'b1, 8'h70 + br3(k));
            exp = 8'h60 + 8'(k);
            n_cmp++; if (bus.o_data !== exp || bus.o_vld !== 1'b1) begin n_err++; $display("FAIL rstv_data k=%0d: got %h/%b want %h/1", k, bus.o_data, bus.o_vld, exp); end
            n_cmp++; if (bus.o_new_fft !== (k == 0)) begin n_err++; $display("FAIL rstv_new k=%0d: got %b want %b", k, bus.o_new_fft, (k == 0)); end
        end
    endtask

    task automatic test_gapped();
        logic [7:0] exp;
        step(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < c_DP; k++) begin
            step(1'b1, 1'b1, 8'h10 + br3(k));
            n_cmp++; if (bus.o_vld !== 1'b0) begin n_err++; $display("FAIL gap_prime k=%0d: got %b want 0", k, bus.o_vld); end
            repeat (2) step(1'b1, 1'b0, 8'hEE);
        end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < c_DP; k++) begin
                exp = 8'h10 + 8'(f * 16) + 8'(k);
                step(1'b1, 1'b1, 8'h20 + 8'(f * 16) + br3(k));
                n_cmp++; if (bus.o_vld !== 1'b1 || bus.o_data !== exp) begin n_err++; $display("FAIL gap_data f=%0d k=%0d: got %h/%b want %h/1", f, k, bus.o_data, bus.o_vld, exp); end
                n_cmp++; if (bus.o_new_fft !== (k == 0)) begin n_err++; $display("FAIL gap_new f=%0d k=%0d: got %b want %b", f, k, bus.o_new_fft, (k == 0)); end
                for (int g = 0; g < 2; g++) begin
                    step(1'b1, 1'b0, 8'hEE);
                    n_cmp++; if (bus.o_vld !== 1'b0 || bus.o_new_fft !== 1'b0) begin n_err++; $display("FAIL gap_idle f=%0d k=%0d: got %b%b want 00", f, k, bus.o_vld, bus.o_new_fft); end
                    n_cmp++; if (bus.o_data !== exp) begin n_err++; $display("FAIL gap_hold f=%0d k=%0d: got %h want %h", f, k, bus.o_data, exp); end
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp;
        step(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < c_DP; k++) step(1'b1, 1'b1, 8'h10 + br3(k));
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 8'h20 + br3(k));
        n_cmp++; if (bus.o_data !== 8'h12) begin n_err++; $display("FAIL mid_pre: got %h want 12", bus.o_data); end
        step(1'b0, 1'b0, 8'h00);
        n_cmp++; if (bus.o_vld !== 1'b0 || bus.o_new_fft !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags: got %b%b want 00", bus.o_vld, bus.o_new_fft); end
        n_cmp++; if (bus.o_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_data: got %h want 00", bus.o_data); end
        for (int k = 0; k < c_DP; k++) begin
            step(1'b1, 1'b1, 8'h40 + br3(k));
            n_cmp++; if (bus.o_vld !== 1'b0) begin n_err++; $display("FAIL mid_d_vld k=%0d: got %b want 0", k, bus.o_vld); end
        end
        for (int k = 0; k < c_DP; k++) begin
            step(1'b1, 1'b1, 8'h50 + br3(k));
            exp = 8'h40 + 8'(k);
            n_cmp++; if (bus.o_vld !== 1'b1 || bus.o_data !== exp) begin n_err++; $display("FAIL mid_e_data k=%0d: got %h/%b want %h/1", k, bus.o_data, bus.o_vld, exp); end
            n_cmp++; if (bus.o_new_fft !== (k == 0)) begin n_err++; $display("FAIL mid_e_new k=%0d: got %b want %b", k, bus.o_new_fft, (k == 0)); end
        end
    endtask

`ifdef FFT_BIT_REORDER_IDX_EN
    task automatic test_idx();
        step(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < c_DP; k++) step(1'b1, 1'b1, 8'h80 + br3(k));
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < c_DP; k++) begin
                step(1'b1, 1'b1, 8'h90 + br3(k));
                n_cmp++; if (bus.o_idx !== 3'(k)) begin n_err++; $display("FAIL idx_val f=%0d k=%0d: got %0d want %0d", f, k, bus.o_idx, k); end
                n_cmp++; if (bus.o_new_fft !== (k == 0)) begin n_err++; $display("FAIL idx_new f=%0d k=%0d: got %b want %b", f, k, bus.o_new_fft, (k == 0)); end
            end
        end
        step(1'b1, 1'b0, 8'h00);
        n_cmp++; if (bus.o_idx !== 3'd7) begin n_err++; $display("FAIL idx_hold: got %0d want 7", bus.o_idx); end
    endtask
`endif

    initial begin
        bus.i_vld  = 1'b0;
        bus.i_data = '0;
        test_reset();
        test_priming();
        test_natural_order();
        test_reset_vs_vld();
        test_gapped();
        test_reset_midframe();
`ifdef FFT_BIT_REORDER_IDX_EN
        test_idx();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
